sipo_deser: RTL and testbench

Parametrised serial-in, parallel-out deserialiser with bit counting, word framing and a valid/ready output handshake. It collects WIDTH serial bits into a shift register, transfers each complete word to an output holding register and presents it to a downstream consumer. It also forwards the bit shifted off the far end for cascading. It is the general-purpose replacement for the fixed 3-bit SIPO chain in serial receive paths.

---
 rtl/sipo_deser.sv | 144 ++++++++++++++
 tb/tb_sipo_deser.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with framing, overrun flag and valid/ready output.
// Optional parity frame bit and parity_err output under `SIPO_DESER_PARITY_EN.
module sipo_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sin,
  input  logic                         sin_en,
  input  logic                         clr,
  output logic [WIDTH-1:0]             pout,
  output logic                         pout_valid,
  input  logic                         pout_ready,
  output logic                         sout,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt,
  output logic                         overrun
`ifdef SIPO_DESER_PARITY_EN
  ,
  output logic                         parity_err
`endif
);

  localparam int CW = $clog2(WIDTH+1);
`ifdef SIPO_DESER_PARITY_EN
  localparam int LAST = WIDTH;
`else
  localparam int LAST = WIDTH - 1;
`endif
  localparam logic [CW-1:0] LAST_C = CW'(LAST);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pv_q, pv_d;
  logic             sout_q, sout_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovr_q, ovr_d;
`ifdef SIPO_DESER_PARITY_EN
  logic             perr_q, perr_d;
`endif

  logic [WIDTH-1:0] sr_sh;
  logic             sh_out;
  logic             last;
  logic             data_bit;
  logic             done;
  logic [WIDTH-1:0] word;

  always_comb begin
    if (MSB_FIRST) begin
      sr_sh  = {sr_q[WIDTH-2:0], sin};
      sh_out = sr_q[WIDTH-1];
    end else begin
      sr_sh  = {sin, sr_q[WIDTH-1:1]};
      sh_out = sr_q[0];
    end
  end

  assign last = (cnt_q == LAST_C);
  assign done = sin_en && last;

  // The parity bit closes the frame but never enters the shift register.
`ifdef SIPO_DESER_PARITY_EN
  assign data_bit = sin_en && !last;
  assign word     = sr_q;
`else
  assign data_bit = sin_en;
  assign word     = sr_sh;
`endif

  always_comb begin
    sr_d   = sr_q;
    pout_d = pout_q;
    pv_d   = pv_q;
    sout_d = sout_q;
    cnt_d  = cnt_q;
    ovr_d  = ovr_q;
`ifdef SIPO_DESER_PARITY_EN
    perr_d = perr_q;
`endif
    if (clr) begin
      sr_d  = '0;
      cnt_d = '0;
      ovr_d = 1'b0;
    end else begin
      if (pv_q && pout_ready) begin
        pv_d = 1'b0;
      end
      if (data_bit) begin
        sr_d   = sr_sh;
        sout_d = sh_out;
      end
      if (sin_en) begin
        cnt_d = last ? '0 : cnt_q + 1'b1;
      end
      // A full holding register that is not being consumed drops the word.
      if (done) begin
        if (!pv_q || pout_ready) begin
          pout_d = word;
          pv_d   = 1'b1;
`ifdef SIPO_DESER_PARITY_EN
          perr_d = (^word) ^ sin;
`endif
        end else begin
          ovr_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q   <= '0;
      pout_q <= '0;
      pv_q   <= 1'b0;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      sr_q   <= sr_d;
      pout_q <= pout_d;
      pv_q   <= pv_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_d;
`ifdef SIPO_DESER_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end

  assign pout       = pout_q;
  assign pout_valid = pv_q;
  assign sout       = sout_q;
  assign bit_cnt    = cnt_q;
  assign overrun    = ovr_q;
`ifdef SIPO_DESER_PARITY_EN
  assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances against a queue-based model.
// Directed test-plan steps followed by a randomized phase.
module tb_sipo_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sin = 1'b0;
  logic sin_en = 1'b0;
  logic clr = 1'b0;
  logic pout_ready = 1'b0;

  logic [W-1:0]  pout_m, pout_l;
  logic          pv_m, pv_l;
  logic          sout_m, sout_l;
  logic [CW-1:0] cnt_m, cnt_l;
  logic          ovr_m, ovr_l;

  always #5 clk = ~clk;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clr(clr),
    .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
    .sout(sout_m), .bit_cnt(cnt_m), .overrun(ovr_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .clr(clr),
    .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
    .sout(sout_l), .bit_cnt(cnt_l), .overrun(ovr_l)
  );

  int errors = 0;
  int checks = 0;

  bit       fq[$];
  bit       hq[$];
  logic [W-1:0] e_pm, e_pl;
  logic     e_pv, e_ov, e_so;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flush_hist();
    hq.delete();
    for (int i = 0; i < W; i++) hq.push_back(1'b0);
  endtask

  task automatic model_edge(input logic b, input logic en, input logic c,
                            input logic r, input logic rs);
    logic [W-1:0] wm, wl;
    if (rs) begin
      fq.delete();
      flush_hist();
      e_pm = '0; e_pl = '0; e_pv = 1'b0; e_ov = 1'b0; e_so = 1'b0;
    end else if (c) begin
      fq.delete();
      flush_hist();
      e_ov = 1'b0;
    end else begin
      if (e_pv && r) e_pv = 1'b0;
      if (en) begin
        fq.push_back(b);
        hq.push_back(b);
        e_so = hq.pop_front();
        if (fq.size() == W) begin
          wm = '0; wl = '0;
          for (int i = 0; i < W; i++) begin
            wm = wm | (W'(fq[i]) << (W-1-i));
            wl = wl | (W'(fq[i]) << i);
          end
          if (!e_pv || r) begin
            e_pm = wm; e_pl = wl; e_pv = 1'b1;
          end else begin
            e_ov = 1'b1;
          end
          fq.delete();
        end
      end
    end
  endtask

  task automatic step(input logic b, input logic en, input logic c,
                      input logic r, input logic rs);
    sin = b; sin_en = en; clr = c; pout_ready = r; rst = rs;
    @(posedge clk);
    model_edge(b, en, c, r, rs);
    #1;
    chk("pout_msb", 32'(pout_m), 32'(e_pm));
    chk("pout_lsb", 32'(pout_l), 32'(e_pl));
    chk("valid_msb", 32'(pv_m), 32'(e_pv));
    chk("valid_lsb", 32'(pv_l), 32'(e_pv));
    chk("ovr_msb", 32'(ovr_m), 32'(e_ov));
    chk("ovr_lsb", 32'(ovr_l), 32'(e_ov));
    chk("sout_msb", 32'(sout_m), 32'(e_so));
    chk("sout_lsb", 32'(sout_l), 32'(e_so));
    chk("cnt_msb", 32'(cnt_m), 32'(fq.size()));
    chk("cnt_lsb", 32'(cnt_l), 32'(fq.size()));
  endtask

  task automatic send_msb(input logic [W-1:0] w, input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(w[W-1-i], 1'b1, 1'b0, (i == W-1) ? rdy_last : 1'b0, 1'b0);
  endtask

  initial begin
    logic [W-1:0] v;
    int acc;
    flush_hist();
    e_pm = '0; e_pl = '0; e_pv = 1'b0; e_ov = 1'b0; e_so = 1'b0;

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_valid", 32'(pv_m), 32'd0);
    chk("rst_cnt", 32'(cnt_m), 32'd0);

    send_msb(8'hA5, 1'b0);
    chk("a5_pout", 32'(pout_m), 32'hA5);
    chk("a5_valid", 32'(pv_m), 32'd1);
    chk("a5_cnt", 32'(cnt_m), 32'd0);
    chk("a5_ovr", 32'(ovr_m), 32'd0);

    send_msb(8'h3C, 1'b0);
    chk("ovr_pout", 32'(pout_m), 32'hA5);
    chk("ovr_set", 32'(ovr_m), 32'd1);

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clr_ovr", 32'(ovr_m), 32'd0);
    chk("clr_valid", 32'(pv_m), 32'd1);
    chk("clr_cnt", 32'(cnt_m), 32'd0);

    send_msb(8'h3C, 1'b1);
    chk("repl_pout", 32'(pout_m), 32'h3C);
    chk("repl_valid", 32'(pv_m), 32'd1);
    chk("repl_ovr", 32'(ovr_m), 32'd0);

    v = 8'h03;
    for (int i = 0; i < W; i++)
      step(v[i], 1'b1, 1'b0, (i == 0) ? 1'b1 : 1'b0, 1'b0);
    chk("lsb_03", 32'(pout_l), 32'h03);
    chk("lsb_msb_c0", 32'(pout_m), 32'hC0);

    acc = 0;
    for (int k = 0; k < 100 && acc < 5; k++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      step(1'($urandom), e, 1'b0, 1'b1, 1'b0);
      if (e) acc++;
    end
    chk("gap_cnt", 32'(cnt_m), 32'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst2_pout", 32'(pout_m), 32'd0);
    chk("rst2_valid", 32'(pv_m), 32'd0);
    chk("rst2_cnt", 32'(cnt_m), 32'd0);

    acc = 0;
    for (int k = 0; k < 100 && acc < W; k++) begin
      logic e;
      e = 1'($urandom_range(0, 1));
      step(1'b1, e, 1'b0, 1'b0, 1'b0);
      if (e) acc++;
    end
    chk("ff_pout", 32'(pout_m), 32'hFF);
    chk("ff_pout_lsb", 32'(pout_l), 32'hFF);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("sout_lag", 32'(sout_m), 32'd1);

    for (int k = 0; k < 400; k++) begin
      step(1'($urandom), ($urandom % 4) != 0, ($urandom % 40) == 0,
           1'($urandom), ($urandom % 150) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
